ibex_vector_load_unit: RTL and testbench

IBEX_VECTOR_LOAD_UNIT -- requirements
Module: ibex_vector_load_unit

---
 rtl/ibex_vector_load_unit.sv | 96 +++++++++
 tb/tb_ibex_vector_load_unit.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/ibex_vector_load_unit.sv
// ibex_vector_load_unit: word-by-word vector load into a 128b register-file write beat
module ibex_vector_load_unit (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         req_valid_i,
  output logic         req_ready_o,
  input  logic [31:0]  req_addr_i,
  input  logic [4:0]   req_vd_i,
  input  logic [2:0]   vlmul_i,
  output logic         data_req_o,
  input  logic         data_gnt_i,
  output logic [31:0]  data_addr_o,
  output logic         data_we_o,
  output logic [3:0]   data_be_o,
  input  logic         data_rvalid_i,
  input  logic [31:0]  data_rdata_i,
  input  logic         data_err_i,
  output logic [127:0] v_wdata_o,
  output logic [4:0]   v_waddr_o,
  output logic         v_we_o,
  output logic         v_load_en_o,
  output logic [3:0]   v_wnum_o,
  output logic         resp_valid_o,
  output logic         resp_err_o,
  input  logic         resp_ready_i,
  output logic         busy_o
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, WRITE, DONE} state_t;
  state_t         state, state_nxt;
  logic [31:0]    base;
  logic [4:0]     vd;
  logic [1:0]     last, cnt, slice;
  logic [127:0]   buffer;
  logic           err, accept, illegal, rv;
  assign accept  = req_valid_i & (state == IDLE);
  assign rv      = data_rvalid_i & (state == WAIT);
  assign illegal = (vlmul_i > 3'd2) | (|req_addr_i[1:0]) |
                   ((vlmul_i == 3'd1) & req_vd_i[0]) |
                   ((vlmul_i == 3'd2) & (|req_vd_i[1:0]));
  // groups of 1 land in the vd-selected slice, groups of 2 in the vd-selected half
  assign slice = (last == 2'd0) ? vd[1:0] :
                 (last == 2'd1) ? {vd[1], 1'b0} + cnt : cnt;
  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = accept ? (illegal ? DONE : REQ) : IDLE;
      REQ:     state_nxt = data_gnt_i ? WAIT : REQ;
      WAIT:    state_nxt = !data_rvalid_i ? WAIT : data_err_i ? DONE :
                           (cnt == last) ? WRITE : REQ;
      WRITE:   state_nxt = DONE;
      DONE:    state_nxt = resp_ready_i ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
  end
  // state, request context and assembly buffer
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state  <= IDLE;
      base   <= '0;
      vd     <= '0;
      last   <= '0;
      cnt    <= '0;
      buffer <= '0;
      err    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        base   <= req_addr_i;
        vd     <= req_vd_i;
        last   <= (vlmul_i == 3'd1) ? 2'd1 : (vlmul_i == 3'd2) ? 2'd3 : 2'd0;
        cnt    <= '0;
        buffer <= '0;
        err    <= illegal;
      end else if (rv && data_err_i) begin
        err <= 1'b1;
      end else if (rv) begin
        buffer[{slice, 5'd0} +: 32] <= data_rdata_i;
        cnt <= cnt + 2'd1;
      end
    end
  end
  assign req_ready_o  = (state == IDLE);
  assign busy_o       = (state != IDLE);
  assign data_req_o   = (state == REQ);
  assign data_addr_o  = data_req_o ? base + {28'd0, cnt, 2'b00} : '0;
  assign data_we_o    = 1'b0;
  assign data_be_o    = 4'b1111;
  assign v_we_o       = (state == WRITE);
  assign v_load_en_o  = v_we_o;
  assign v_waddr_o    = v_we_o ? vd : '0;
  assign v_wdata_o    = v_we_o ? buffer : '0;
  assign v_wnum_o     = 4'd0;
  assign resp_valid_o = (state == DONE);
  assign resp_err_o   = resp_valid_o & err;
endmodule

// File: tb/tb_ibex_vector_load_unit.sv
// tb_ibex_vector_load_unit: randomized self-checking bench with a transaction-level model
module tb_ibex_vector_load_unit;
  logic         clk = 1'b0;
  logic         rstn_i, req_valid_i, req_ready_o, data_req_o, data_gnt_i, data_we_o;
  logic [31:0]  req_addr_i, data_addr_o, data_rdata_i;
  logic [4:0]   req_vd_i, v_waddr_o;
  logic [2:0]   vlmul_i;
  logic [3:0]   data_be_o, v_wnum_o;
  logic         data_rvalid_i, data_err_i, v_we_o, v_load_en_o;
  logic         resp_valid_o, resp_err_o, resp_ready_i, busy_o;
  logic [127:0] v_wdata_o;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  ibex_vector_load_unit dut (
    .clk_i(clk), .rstn_i(rstn_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_vd_i(req_vd_i), .vlmul_i(vlmul_i),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_addr_o(data_addr_o),
    .data_we_o(data_we_o), .data_be_o(data_be_o), .data_rvalid_i(data_rvalid_i),
    .data_rdata_i(data_rdata_i), .data_err_i(data_err_i), .v_wdata_o(v_wdata_o),
    .v_waddr_o(v_waddr_o), .v_we_o(v_we_o), .v_load_en_o(v_load_en_o), .v_wnum_o(v_wnum_o),
    .resp_valid_o(resp_valid_o), .resp_err_o(resp_err_o), .resp_ready_i(resp_ready_i),
    .busy_o(busy_o)
  );
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic idle_mem();
    data_gnt_i = 0; data_rvalid_i = 0; data_err_i = 0; data_rdata_i = $urandom;
  endtask
  // one load: gdly<0 means random grant delay, hold<0 random response back-pressure
  task automatic do_load(input logic [31:0] addr, input logic [4:0] vd, input logic [2:0] vlmul,
                         input int err_at, input int gdly, input int hold, input logic [31:0] wd[4]);
    int n, nreq, nwr, rv_dly, g_cnt, cyc, resp_cyc, wr_cyc, s, hl, eff_err;
    bit legal, pend, done, bad;
    logic [31:0] words[4];
    logic [31:0] last_addr;
    logic [127:0] got_w, exp_w;
    logic [4:0] got_a;
    n = (vlmul == 0) ? 1 : (vlmul == 1) ? 2 : (vlmul == 2) ? 4 : 0;
    legal = n != 0 && addr[1:0] == 0 && !(n == 2 && vd[0]) && !(n == 4 && vd[1:0] != 0);
    eff_err = (err_at >= 0 && err_at < n) ? err_at : -1;
    bad = !legal || eff_err >= 0;
    nreq = 0; nwr = 0; rv_dly = -1; cyc = 0; resp_cyc = -1; wr_cyc = -1;
    pend = 0; done = 0; got_w = 0; got_a = 0; last_addr = 0;
    for (int i = 0; i < 4; i++) words[i] = 0;
    check("ready_before", req_ready_o, 1);
    req_valid_i = 1; req_addr_i = addr; req_vd_i = vd; vlmul_i = vlmul;
    @(negedge clk);
    req_valid_i = 0; req_addr_i = $urandom; req_vd_i = 5'($urandom); vlmul_i = 3'($urandom);
    g_cnt = gdly < 0 ? $urandom_range(0, 2) : gdly;
    while (!done && cyc < 300) begin
      idle_mem();
      if (v_we_o) begin nwr++; got_w = v_wdata_o; got_a = v_waddr_o; wr_cyc = cyc; end
      if (data_req_o) begin
        check("one_outstanding", rv_dly >= 0, 0);
        if (pend) check("addr_stable", data_addr_o, last_addr);
        else begin check("addr", data_addr_o, addr + 4 * nreq); nreq++; end
        last_addr = data_addr_o; pend = 1;
        if (g_cnt == 0) begin
          data_gnt_i = 1; pend = 0;
          rv_dly = gdly < 0 ? $urandom_range(0, 2) : 0;
          g_cnt = gdly < 0 ? $urandom_range(0, 2) : gdly;
        end else g_cnt--;
      end else if (rv_dly == 0) begin
        data_rvalid_i = 1; rv_dly = -1;
        if (nreq >= 1 && nreq <= 4) begin
          data_rdata_i = wd[nreq-1];
          words[nreq-1] = wd[nreq-1];
          data_err_i = (nreq - 1 == eff_err);
        end
      end else if (rv_dly > 0) rv_dly--;
      else if ($urandom_range(0, 3) == 0) begin
        data_rvalid_i = 1; data_err_i = 1'($urandom);
      end
      if (resp_valid_o) begin
        resp_cyc = cyc;
        check("resp_err", resp_err_o, bad);
        hl = hold < 0 ? $urandom_range(0, 3) : hold;
        for (int h = 0; h < hl; h++) begin
          @(negedge clk); idle_mem();
          check("hold_valid", resp_valid_o, 1);
          check("hold_ready", req_ready_o, 0);
        end
        resp_ready_i = 1;
        @(negedge clk);
        resp_ready_i = 0; idle_mem();
        done = 1;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    check("timeout", done, 1);
    check("nreq", nreq, !legal ? 0 : eff_err >= 0 ? eff_err + 1 : n);
    check("nwrite", nwr, bad ? 0 : 1);
    if (!bad) begin
      exp_w = 0;
      for (int i = 0; i < n; i++) begin
        s = (n == 1) ? int'(vd[1:0]) : (n == 2) ? 2 * int'(vd[1]) + i : i;
        exp_w[s*32 +: 32] = words[i];
      end
      check("wdata", got_w, exp_w);
      check("waddr", got_a, vd);
      if (gdly == 0) check("latency", wr_cyc, 2 * n);
    end
    if (!legal) check("illegal_lat", resp_cyc <= 1, 1);
  endtask
  logic [31:0] wd[4];
  initial begin
    rstn_i = 0; req_valid_i = 0; req_addr_i = 0; req_vd_i = 0; vlmul_i = 0;
    resp_ready_i = 0; idle_mem();
    repeat (2) @(negedge clk);
    check("rst_ready", req_ready_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_dreq", data_req_o, 0);
    check("rst_daddr", data_addr_o, 0);
    check("rst_be", data_be_o, 4'hf);
    check("rst_we", {data_we_o, v_we_o, v_load_en_o, v_wnum_o}, 0);
    check("rst_wdata", v_wdata_o, 0);
    check("rst_resp", {resp_valid_o, resp_err_o}, 0);
    rstn_i = 1;
    @(negedge clk);
    wd = '{32'hA5A5A5A5, 0, 0, 0};
    do_load(32'h100, 5'd6, 3'b000, -1, 0, 0, wd);
    wd = '{32'h11, 32'h22, 32'h33, 32'h44};
    do_load(32'h200, 5'd8, 3'b010, -1, 3, 1, wd);
    do_load(32'h100, 5'd3, 3'b001, -1, 0, 0, wd);
    do_load(32'h102, 5'd4, 3'b001, -1, 0, 0, wd);
    do_load(32'h300, 5'd0, 3'b010, 1, 1, 0, wd);
    do_load(32'h400, 5'd0, 3'b000, -1, 0, 0, wd);
    do_load(32'h500, 5'd10, 3'b001, -1, 0, 5, wd);
    // reset while waiting for read data, then a late rvalid
    req_valid_i = 1; req_addr_i = 32'h40; req_vd_i = 5'd4; vlmul_i = 3'b000;
    @(negedge clk);
    req_valid_i = 0; data_gnt_i = 1;
    @(negedge clk);
    data_gnt_i = 0; rstn_i = 0;
    @(negedge clk);
    rstn_i = 1;
    @(negedge clk);
    check("rst_abort_idle", {req_ready_o, busy_o}, 2'b10);
    data_rvalid_i = 1; data_rdata_i = 32'hDEAD;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); idle_mem();
      check("rst_abort_quiet", {v_we_o, resp_valid_o, data_req_o}, 0);
    end
    wd = '{32'hCAFE0001, 0, 0, 0};
    do_load(32'h80, 5'd5, 3'b000, -1, 0, 0, wd);
    for (int t = 0; t < 60; t++) begin
      logic [2:0] vl;
      logic [4:0] v;
      logic [31:0] a;
      vl = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      v = 5'($urandom);
      if ($urandom_range(0, 3) != 0) v = (vl == 1) ? {v[4:1], 1'b0} : (vl == 2) ? {v[4:2], 2'b0} : v;
      a = $urandom;
      if ($urandom_range(0, 5) != 0) a[1:0] = 0;
      for (int i = 0; i < 4; i++) wd[i] = $urandom;
      do_load(a, v, vl, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1, -1, -1, wd);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
